// File: rtl/demux_router.sv
// 1-to-4 demultiplexing router: one input stream steered by a 2-bit address into
// per-channel one-entry holding registers, each with valid/ready and a transfer counter.
module demux_router #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [1:0]             in_address,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [4*WIDTH-1:0]     out_data,
  output logic [3:0]             out_valid,
  input  logic [3:0]             out_ready,
  output logic [4*CNT_WIDTH-1:0] out_count
);

  localparam int unsigned NumCh = 4;

  logic [NumCh-1:0][WIDTH-1:0]     data_q, data_d;
  logic [NumCh-1:0][CNT_WIDTH-1:0] count_q, count_d;
  logic [NumCh-1:0]                valid_q, valid_d;
  logic [NumCh-1:0]                drain;
  logic [NumCh-1:0]                load;
  logic                            accept;

  // A full channel may still take a word when its consumer drains it in the same cycle.
  always_comb begin
    in_ready = rst_n & ~flush & (~valid_q[in_address] | out_ready[in_address]);
  end

  assign accept = in_valid & in_ready;
  assign drain  = valid_q & out_ready;

  always_comb begin
    load             = '0;
    load[in_address] = accept;
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    count_d = count_q;
    for (int n = 0; n < NumCh; n++) begin
      if (drain[n]) begin
        valid_d[n] = 1'b0;
        count_d[n] = count_q[n] + CNT_WIDTH'(1);
      end
      if (load[n]) begin
        valid_d[n] = 1'b1;
        data_d[n]  = in_data;
      end
    end
    // Drains in a flush cycle are still counted above; only the holding state is cleared.
    if (flush) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_count = count_q;

endmodule

// File: tb/tb_demux_router.sv
// Directed bench for demux_router with a scoreboard of routed words checked on every drain.
module tb_demux_router;

  localparam int W  = 32;
  localparam int CW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic [W-1:0]    in_data = '0;
  logic [1:0]      in_address = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [4*W-1:0]  out_data;
  logic [3:0]      out_valid;
  logic [3:0]      out_ready = '0;
  logic [4*CW-1:0] out_count;

  demux_router #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_data    (in_data),
    .in_address (in_address),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_count  (out_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]   ch;
    logic [W-1:0] data;
  } item_t;

  item_t               sb[$];
  logic [3:0]          m_valid = '0;
  logic [3:0][CW-1:0]  m_cnt = '0;
  int                  passed = 0;
  int                  failed = 0;
  int                  total = 0;

  task automatic check(input string tag, input logic [4*W-1:0] obs, input logic [4*W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge with inputs driven; advances one clock and
  // updates the reference model from what crosses each interface at the edge.
  task automatic cycle();
    logic [3:0] drn;
    logic       acc;
    item_t      it;
    int         idx;
    #1;
    check("in_ready", in_ready,
          rst_n & ~flush & (~m_valid[in_address] | out_ready[in_address]));
    acc = in_valid & in_ready;
    drn = m_valid & out_ready;
    for (int n = 0; n < 4; n++) begin
      if (drn[n]) begin
        idx = -1;
        for (int i = 0; i < sb.size(); i++) begin
          if (idx < 0 && sb[i].ch == 2'(n)) idx = i;
        end
        check("sb_has_entry", idx >= 0, 1);
        if (idx >= 0) begin
          check($sformatf("drain_data_ch%0d", n), out_data[n*W +: W], sb[idx].data);
          sb.delete(idx);
        end
        m_cnt[n]   = m_cnt[n] + 1'b1;
        m_valid[n] = 1'b0;
      end
    end
    if (flush) begin
      m_valid = '0;
      sb.delete();
    end
    if (acc) begin
      it.ch   = in_address;
      it.data = in_data;
      sb.push_back(it);
      m_valid[in_address] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check("out_valid_model", out_valid, m_valid);
    check("out_count_model", out_count, m_cnt);
  endtask

  task automatic send(input logic [1:0] a, input logic [W-1:0] d);
    in_address = a;
    in_data    = d;
    in_valid   = 1'b1;
    cycle();
    in_valid   = 1'b0;
  endtask

  initial begin
    // Reset held across several edges
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 4'b0000);
    check("rst_out_count", out_count, '0);
    check("rst_out_data", out_data, '0);
    check("rst_in_ready", in_ready, 1'b0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);
    @(negedge clk);

    // Single route to channel 2, consumer stalled
    send(2'd2, 32'hDEADBEEF);
    check("route_valid", out_valid, 4'b0100);
    check("route_slice2", out_data[2*W +: W], 32'hDEADBEEF);
    in_address = 2'd2;
    in_data    = 32'hCAFE0002;
    in_valid   = 1'b1;
    #1;
    check("full_in_ready", in_ready, 1'b0);
    cycle();
    check("stall_hold_slice2", out_data[2*W +: W], 32'hDEADBEEF);
    out_ready = 4'b0100;
    cycle();
    in_valid = 1'b0;
    check("refill2_slice", out_data[2*W +: W], 32'hCAFE0002);
    cycle();
    check("drained2_valid", out_valid, 4'b0000);
    out_ready = 4'b0000;

    // Pass-through refill on channel 1
    send(2'd1, 32'h1);
    in_address = 2'd1;
    in_data    = 32'h2;
    in_valid   = 1'b1;
    out_ready  = 4'b0010;
    #1;
    check("refill1_in_ready", in_ready, 1'b1);
    cycle();
    in_valid = 1'b0;
    check("refill1_slice", out_data[1*W +: W], 32'h2);
    check("refill1_valid", out_valid[1], 1'b1);
    check("refill1_count", out_count[1*CW +: CW], 8'd1);
    cycle();
    out_ready = 4'b0000;

    // Independence: channel 0 stalled while channel 3 accepts
    send(2'd0, 32'hA0);
    in_address = 2'd3;
    in_data    = 32'h5;
    in_valid   = 1'b1;
    #1;
    check("indep_in_ready", in_ready, 1'b1);
    cycle();
    in_valid = 1'b0;
    check("indep_valid", out_valid, 4'b1001);
    check("indep_slice0", out_data[0 +: W], 32'hA0);
    check("indep_slice3", out_data[3*W +: W], 32'h5);
    out_ready = 4'b1111;
    cycle();
    out_ready = 4'b0000;

    // Counter wrap on channel 0: it already has one transfer, stream 255 more
    out_ready  = 4'b0001;
    in_address = 2'd0;
    in_valid   = 1'b1;
    for (int i = 0; i < 255; i++) begin
      in_data = 32'h100 + i;
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    check("wrap_count0_zero", out_count[0 +: CW], 8'd0);
    send(2'd0, 32'hBEEF);
    cycle();
    check("wrap_count0_one", out_count[0 +: CW], 8'd1);
    out_ready = 4'b0000;

    // Flush with all channels full and only channel 0 draining
    for (int n = 0; n < 4; n++) send(2'(n), 32'h1111_0000 + n);
    check("flush_pre_valid", out_valid, 4'b1111);
    flush      = 1'b1;
    out_ready  = 4'b0001;
    in_address = 2'd1;
    in_data    = 32'h7777;
    in_valid   = 1'b1;
    #1;
    check("flush_in_ready", in_ready, 1'b0);
    cycle();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    check("flush_valid", out_valid, 4'b0000);
    check("flush_count", out_count, 32'h01020202);
    check("flush_data", out_data,
          128'h11110003_11110002_11110001_11110000);

    // Asynchronous reset dropped between edges
    send(2'd2, 32'h9999);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 4'b0000);
    check("async_rst_count", out_count, '0);
    check("async_rst_data", out_data, '0);
    check("async_rst_in_ready", in_ready, 1'b0);
    m_valid = '0;
    m_cnt   = '0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send(2'd1, 32'h4242);
    check("post_async_accept", out_valid, 4'b0010);
    check("post_async_slice1", out_data[1*W +: W], 32'h4242);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
